// File: rtl/cv32e40p_ft_replica_manager.sv
// Fault-tracking and replica-selection controller for the fault-tolerant ALU stage.
// Counts per-replica voter mismatches per observation window and swaps replicas via a drain/ack handshake.
module cv32e40p_ft_replica_manager #(
  parameter int N_REPLICAS  = 4,
  parameter int N_ACTIVE    = 3,
  parameter int PERM_THRESH = 16,
  parameter int WINDOW_LEN  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [N_REPLICAS-1:0] replica_err_i,
  input  logic                  clear_i,
  input  logic                  reconf_ack_i,
  output logic [N_REPLICAS-1:0] clock_gate_pipe_replica_o,
  output logic [N_REPLICAS-1:0] perm_faulty_o,
  output logic                  reconf_req_o,
  output logic                  degraded_o
);

  localparam int CW = $clog2(PERM_THRESH + 1);
  localparam int WW = $clog2(WINDOW_LEN);
  localparam logic [N_REPLICAS-1:0] DEFAULT_MASK = N_REPLICAS'((1 << N_ACTIVE) - 1);

  typedef enum logic {
    S_RUN,
    S_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q [N_REPLICAS];
  logic [CW-1:0]         cnt_d [N_REPLICAS];
  logic [WW-1:0]         win_q;
  logic                  wrap;
  logic [N_REPLICAS-1:0] inc;
  logic [N_REPLICAS-1:0] perm_q, perm_d;
  logic [N_REPLICAS-1:0] mask_q;
  logic [N_REPLICAS-1:0] target;
  logic                  deg_q, deg_d;
  logic                  req_q;
  logic                  load;
  int                    sel_cnt;
  int                    healthy_cnt;

  assign wrap = valid_i && (win_q == WW'(WINDOW_LEN - 1));

  // Window wrap clears before this cycle's increment, so an error on the wrap cycle leaves a count of 1.
  always_comb begin
    perm_d = perm_q;
    inc    = '0;
    for (int k = 0; k < N_REPLICAS; k++) begin
      cnt_d[k] = cnt_q[k];
      inc[k]   = valid_i & replica_err_i[k] & mask_q[k] & ~perm_q[k];
      if (clear_i) begin
        cnt_d[k]  = '0;
        perm_d[k] = 1'b0;
      end else begin
        if (wrap && !perm_q[k]) begin
          cnt_d[k] = inc[k] ? CW'(1) : '0;
        end else if (inc[k] && (cnt_q[k] != CW'(PERM_THRESH))) begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
        if (cnt_d[k] == CW'(PERM_THRESH)) begin
          perm_d[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    healthy_cnt = 0;
    for (int k = 0; k < N_REPLICAS; k++) begin
      if (!perm_d[k]) begin
        healthy_cnt = healthy_cnt + 1;
      end
    end
    deg_d = (healthy_cnt < N_ACTIVE);
  end

  // Lowest-index healthy replicas; once degraded the current mask is frozen.
  always_comb begin
    target  = '0;
    sel_cnt = 0;
    for (int k = 0; k < N_REPLICAS; k++) begin
      if (!perm_q[k] && (sel_cnt < N_ACTIVE)) begin
        target[k] = 1'b1;
        sel_cnt   = sel_cnt + 1;
      end
    end
    if (deg_q) begin
      target = mask_q;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_RUN: begin
        if ((target != mask_q) && !deg_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (reconf_ack_i) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      mask_q  <= DEFAULT_MASK;
      perm_q  <= '0;
      deg_q   <= 1'b0;
      req_q   <= 1'b0;
      win_q   <= '0;
      for (int k = 0; k < N_REPLICAS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == S_DRAIN);
      perm_q  <= perm_d;
      deg_q   <= deg_d;
      if (load) begin
        mask_q <= target;
      end
      if (clear_i) begin
        win_q <= '0;
      end else if (valid_i) begin
        win_q <= wrap ? '0 : win_q + WW'(1);
      end
      for (int k = 0; k < N_REPLICAS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign clock_gate_pipe_replica_o = mask_q;
  assign perm_faulty_o             = perm_q;
  assign reconf_req_o              = req_q;
  assign degraded_o                = deg_q;

endmodule

// File: tb/tb_cv32e40p_ft_replica_manager.sv
// Directed bench: two instances (3-of-4 and 2-of-4 active) share stimulus; THRESH=4, WINDOW=16.
module tb_cv32e40p_ft_replica_manager;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [3:0] replica_err;
  logic       clear;
  logic       reconf_ack;
  logic [3:0] mask, perm, mask2, perm2;
  logic       req, deg, req2, deg2;
  int         tests;
  int         fails;

  cv32e40p_ft_replica_manager #(
    .N_REPLICAS(4), .N_ACTIVE(3), .PERM_THRESH(4), .WINDOW_LEN(16)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid), .replica_err_i(replica_err),
    .clear_i(clear), .reconf_ack_i(reconf_ack),
    .clock_gate_pipe_replica_o(mask), .perm_faulty_o(perm),
    .reconf_req_o(req), .degraded_o(deg)
  );

  cv32e40p_ft_replica_manager #(
    .N_REPLICAS(4), .N_ACTIVE(2), .PERM_THRESH(4), .WINDOW_LEN(16)
  ) dut2 (
    .clk(clk), .rst(rst), .valid_i(valid), .replica_err_i(replica_err),
    .clear_i(clear), .reconf_ack_i(reconf_ack),
    .clock_gate_pipe_replica_o(mask2), .perm_faulty_o(perm2),
    .reconf_req_o(req2), .degraded_o(deg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; replica_err = '0; clear = 1'b0; reconf_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] err, input int n);
    for (int i = 0; i < n; i++) begin
      valid = 1'b1;
      replica_err = err;
      tick();
    end
    valid = 1'b0;
    replica_err = '0;
  endtask

  task automatic ack_once();
    reconf_ack = 1'b1;
    tick();
    reconf_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (mask !== 4'b0111) begin fails++; $display("[TB] FAIL reset_mask got %b expected 0111", mask); end
    tests++; if (perm !== 4'b0000) begin fails++; $display("[TB] FAIL reset_perm got %b expected 0000", perm); end
    tests++; if (req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req got %b expected 0", req); end
    tests++; if (deg !== 1'b0) begin fails++; $display("[TB] FAIL reset_deg got %b expected 0", deg); end
    tests++; if (mask2 !== 4'b0011) begin fails++; $display("[TB] FAIL reset_mask2 got %b expected 0011", mask2); end
    applyStimulus(4'b1000, 5);
    tests++; if (perm !== 4'b0000) begin fails++; $display("[TB] FAIL gated_err_perm got %b expected 0000", perm); end
    tick();
    tests++; if (req !== 1'b0) begin fails++; $display("[TB] FAIL gated_err_req got %b expected 0", req); end
  endtask

  task automatic test_perm_fault();
    do_reset();
    applyStimulus(4'b0001, 3);
    tests++; if (perm !== 4'b0000) begin fails++; $display("[TB] FAIL below_thresh_perm got %b expected 0000", perm); end
    applyStimulus(4'b0001, 1);
    tests++; if (perm !== 4'b0001) begin fails++; $display("[TB] FAIL thresh_perm got %b expected 0001", perm); end
    tests++; if (req !== 1'b0) begin fails++; $display("[TB] FAIL thresh_req_early got %b expected 0", req); end
    tick();
    tests++; if (req !== 1'b1) begin fails++; $display("[TB] FAIL thresh_req got %b expected 1", req); end
    repeat (5) tick();
    tests++; if (mask !== 4'b0111) begin fails++; $display("[TB] FAIL drain_wait_mask got %b expected 0111", mask); end
    tests++; if (req !== 1'b1) begin fails++; $display("[TB] FAIL drain_wait_req got %b expected 1", req); end
    ack_once();
    tests++; if (mask !== 4'b1110) begin fails++; $display("[TB] FAIL reconf_mask got %b expected 1110", mask); end
    tests++; if (req !== 1'b0) begin fails++; $display("[TB] FAIL reconf_req got %b expected 0", req); end
  endtask

  task automatic test_window();
    do_reset();
    applyStimulus(4'b0010, 3);
    applyStimulus(4'b0000, 13);
    applyStimulus(4'b0010, 1);
    tests++; if (perm !== 4'b0000) begin fails++; $display("[TB] FAIL wrap_clear_perm got %b expected 0000", perm); end
    applyStimulus(4'b0010, 2);
    tests++; if (perm !== 4'b0000) begin fails++; $display("[TB] FAIL wrap_count3_perm got %b expected 0000", perm); end
    applyStimulus(4'b0000, 12);
    applyStimulus(4'b0010, 1);
    applyStimulus(4'b0010, 2);
    tests++; if (perm !== 4'b0000) begin fails++; $display("[TB] FAIL wrap_err_count_perm got %b expected 0000", perm); end
    applyStimulus(4'b0010, 1);
    tests++; if (perm !== 4'b0010) begin fails++; $display("[TB] FAIL wrap_err_flag_perm got %b expected 0010", perm); end
  endtask

  task automatic test_multi_fault();
    do_reset();
    applyStimulus(4'b0001, 4);
    tick();
    ack_once();
    tests++; if (mask !== 4'b1110) begin fails++; $display("[TB] FAIL multi_a3_mask1 got %b expected 1110", mask); end
    tests++; if (mask2 !== 4'b0110) begin fails++; $display("[TB] FAIL multi_a2_mask1 got %b expected 0110", mask2); end
    applyStimulus(4'b0100, 4);
    tests++; if (perm !== 4'b0101) begin fails++; $display("[TB] FAIL multi_perm2 got %b expected 0101", perm); end
    tests++; if (deg !== 1'b1) begin fails++; $display("[TB] FAIL multi_a3_deg got %b expected 1", deg); end
    tests++; if (deg2 !== 1'b0) begin fails++; $display("[TB] FAIL multi_a2_deg got %b expected 0", deg2); end
    tick();
    tests++; if (req !== 1'b0) begin fails++; $display("[TB] FAIL multi_a3_no_req got %b expected 0", req); end
    tests++; if (req2 !== 1'b1) begin fails++; $display("[TB] FAIL multi_a2_req got %b expected 1", req2); end
    ack_once();
    tests++; if (mask2 !== 4'b1010) begin fails++; $display("[TB] FAIL multi_a2_mask2 got %b expected 1010", mask2); end
    tests++; if (mask !== 4'b1110) begin fails++; $display("[TB] FAIL multi_a3_frozen got %b expected 1110", mask); end
    applyStimulus(4'b0010, 4);
    tests++; if (deg2 !== 1'b1) begin fails++; $display("[TB] FAIL multi_a2_deg2 got %b expected 1", deg2); end
    tick();
    tests++; if (req2 !== 1'b0) begin fails++; $display("[TB] FAIL multi_a2_no_req got %b expected 0", req2); end
    tests++; if (mask2 !== 4'b1010) begin fails++; $display("[TB] FAIL multi_a2_frozen got %b expected 1010", mask2); end
  endtask

  task automatic test_drain_fault();
    do_reset();
    applyStimulus(4'b0001, 4);
    tick();
    applyStimulus(4'b0010, 4);
    tests++; if (perm2 !== 4'b0011) begin fails++; $display("[TB] FAIL drainf_perm got %b expected 0011", perm2); end
    tests++; if (req2 !== 1'b1) begin fails++; $display("[TB] FAIL drainf_req got %b expected 1", req2); end
    ack_once();
    tests++; if (mask2 !== 4'b1100) begin fails++; $display("[TB] FAIL drainf_a2_mask got %b expected 1100", mask2); end
    tests++; if (req2 !== 1'b0) begin fails++; $display("[TB] FAIL drainf_a2_req got %b expected 0", req2); end
    tests++; if (mask !== 4'b0111) begin fails++; $display("[TB] FAIL drainf_a3_mask got %b expected 0111", mask); end
    tests++; if (deg !== 1'b1) begin fails++; $display("[TB] FAIL drainf_a3_deg got %b expected 1", deg); end
  endtask

  task automatic test_clear();
    do_reset();
    applyStimulus(4'b0001, 4);
    tick();
    ack_once();
    applyStimulus(4'b0010, 3);
    clear = 1'b1;
    applyStimulus(4'b0010, 1);
    clear = 1'b0;
    tests++; if (perm !== 4'b0000) begin fails++; $display("[TB] FAIL clear_perm got %b expected 0000", perm); end
    tests++; if (deg !== 1'b0) begin fails++; $display("[TB] FAIL clear_deg got %b expected 0", deg); end
    tick();
    tests++; if (req !== 1'b1) begin fails++; $display("[TB] FAIL clear_req got %b expected 1", req); end
    ack_once();
    tests++; if (mask !== 4'b0111) begin fails++; $display("[TB] FAIL clear_mask got %b expected 0111", mask); end
    tests++; if (mask2 !== 4'b0011) begin fails++; $display("[TB] FAIL clear_mask2 got %b expected 0011", mask2); end
    applyStimulus(4'b0010, 3);
    tests++; if (perm !== 4'b0000) begin fails++; $display("[TB] FAIL clear_cnt_perm got %b expected 0000", perm); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    applyStimulus(4'b0001, 4);
    tick();
    rst = 1'b1;
    #1;
    tests++; if (mask !== 4'b0111) begin fails++; $display("[TB] FAIL rst_drain_mask got %b expected 0111", mask); end
    tests++; if (req !== 1'b0) begin fails++; $display("[TB] FAIL rst_drain_req got %b expected 0", req); end
    tests++; if (perm !== 4'b0000) begin fails++; $display("[TB] FAIL rst_drain_perm got %b expected 0000", perm); end
    rst = 1'b0;
    tick();
    tests++; if (req !== 1'b0) begin fails++; $display("[TB] FAIL rst_drain_after got %b expected 0", req); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_perm_fault();
    test_window();
    test_multi_fault();
    test_drain_fault();
    test_clear();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
